pe_seq_ctrl: RTL

// - Programmable sequencer for the single-PE BRAM datapath: streams LEN words from input BRAM port A through the PE pipeline.
// - Writes LEN results to output BRAM port B.
// - Replaces fixed 8-word counter sequencing; variable length, base addresses and pipeline latency.
// - Sits between the AXI/GPIO control regs and the BRAM ports / PE pipeline registers.

---
 rtl/pe_seq_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/pe_seq_ctrl.sv
// pe_seq_ctrl: programmable read/write sequencer for the single-PE BRAM datapath.
// Streams len words from port A, delays the read strobe by LAT cycles and
// issues the matching writes on port B.
// Optional build macro: PE_SEQ_ABORT_EN adds an abort input that stops reads early.
module pe_seq_ctrl #(
  parameter int unsigned LEN_W = 16,
  parameter int unsigned LAT   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [31:0]      base_a,
  input  logic [31:0]      base_b,
`ifdef PE_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             ena,
  output logic [31:0]      addra,
  output logic             enb,
  output logic [3:0]       web,
  output logic [31:0]      addrb
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  state_t           state;
  logic             start_q;
  logic [LAT-1:0]   dly;
  logic [LEN_W-1:0] rd_cnt;
  logic [LEN_W-1:0] wr_cnt;
  logic [LEN_W-1:0] wr_tgt;
  logic             abort_i;

`ifdef PE_SEQ_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Write strobe is the read strobe delayed LAT cycles; web follows it.
  assign enb = dly[LAT-1];
  assign web = {4{enb}};

  // Sequencer FSM, read/write counters, address generators and strobe delay line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      ena     <= 1'b0;
      addra   <= '0;
      addrb   <= '0;
      start_q <= 1'b0;
      dly     <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      wr_tgt  <= '0;
    end else begin
      start_q <= start;
      dly[0]  <= ena;
      for (int unsigned i = 1; i < LAT; i++) dly[i] <= dly[i-1];
      done <= 1'b0;

      // addrb always holds the address of the write currently on the port.
      if (enb) begin
        addrb  <= addrb + 32'd4;
        wr_cnt <= wr_cnt + CNT_ONE;
      end

      case (state)
        S_IDLE: begin
          if (start && !start_q) begin
            addrb  <= base_b;
            wr_cnt <= '0;
            wr_tgt <= len;
            ready  <= 1'b0;
            if (len == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state  <= S_RUN;
              busy   <= 1'b1;
              ena    <= 1'b1;
              addra  <= base_a;
              rd_cnt <= CNT_ONE;
            end
          end
        end
        S_RUN: begin
          // On abort the write target shrinks to the reads already issued.
          if (rd_cnt == wr_tgt || abort_i) begin
            ena   <= 1'b0;
            state <= S_DRAIN;
            if (abort_i) wr_tgt <= rd_cnt;
          end else begin
            addra  <= addra + 32'd4;
            rd_cnt <= rd_cnt + CNT_ONE;
          end
        end
        S_DRAIN: begin
          if (enb && wr_cnt == wr_tgt - CNT_ONE) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          ready <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
